// File: rtl/octree_mem_bridge.sv
// ---------------------------------------------------------------------------
// octree_mem_bridge
//
// Bridges a simple request/response memory bus to the octree accelerator. The
// bridge exposes a bank of writable CSR words, one read-only status word and
// NUM_REGIONS SRAM regions.
//
// Bus handshake: the bus has no back-pressure. Every cycle with mem_req_i=1 is
// one accepted request. Exactly one cycle later, mem_rvalid_o pulses once for
// that request, for reads and writes alike. mem_err_o and mem_rdata_o are only
// meaningful while mem_rvalid_o=1. mem_rdata_o is 0 on write acks and 0
// whenever mem_rvalid_o=0.
//
// Address map, with offsets taken from BASE_ADDR:
//   CSR word k   : k * 0x1_0000            (k < CSR_WORDS)
//   status word  : CSR_WORDS * 0x1_0000    (read-only, {busy_i, op_done_i})
//   region r     : (r+1) * 0x10_0000       (DEPTH words of DATA_W bits)
// CSR word 0 bits [49:48] are the start field. Writing a nonzero value there
// pulses start_o for one cycle, and the field then clears itself.
// DATA_W must be at least 64 so that the start field exists.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   mem_req_i .. mem_wdata_i bus request (write flag, byte enables, addr, data)
//   mem_rdata_o, mem_rvalid_o, mem_err_o   bus response
//   csr_o                    flattened CSR words (word k at [k*DATA_W +: DATA_W])
//   start_o                  one-cycle accelerator start pulse
//   busy_i, op_done_i        accelerator status
//   sram_*                   SRAM ports shared by all regions, one req bit per
//                            region; sram_rdata_i has 1-cycle read latency
// ---------------------------------------------------------------------------
module octree_mem_bridge #(
    parameter int          DATA_W      = 64,
    parameter int          NUM_REGIONS = 2,
    parameter int          DEPTH       = 1024,
    parameter int          CSR_WORDS   = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h6000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          mem_req_i,
    input  logic                          mem_write_en_i,
    input  logic [DATA_W/8-1:0]           mem_byte_en_i,
    input  logic [63:0]                   mem_addr_i,
    input  logic [DATA_W-1:0]             mem_wdata_i,
    output logic [DATA_W-1:0]             mem_rdata_o,
    output logic                          mem_rvalid_o,
    output logic                          mem_err_o,
    output logic [CSR_WORDS*DATA_W-1:0]   csr_o,
    output logic                          start_o,
    input  logic                          busy_i,
    input  logic [1:0]                    op_done_i,
    output logic [NUM_REGIONS-1:0]        sram_req_o,
    output logic                          sram_we_o,
    output logic [DATA_W/8-1:0]           sram_be_o,
    output logic [$clog2(DEPTH)-1:0]      sram_addr_o,
    output logic [DATA_W-1:0]             sram_wdata_o,
    input  logic [NUM_REGIONS*DATA_W-1:0] sram_rdata_i
);

    localparam int          BYTES        = DATA_W / 8;
    localparam int          WB           = $clog2(BYTES);
    localparam int          AW           = $clog2(DEPTH);
    localparam int          RIW          = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int          CIW          = (CSR_WORDS > 1) ? $clog2(CSR_WORDS) : 1;
    localparam logic [63:0] REGION_BYTES = 64'(DEPTH) * 64'(BYTES);
    localparam int          START_LO     = 48;
    localparam int          START_HI     = 49;

    // ---------------- address decode ----------------
    logic [63:0]    offset;
    logic           csr_hit, stat_hit, reg_hit;
    logic [CIW-1:0] csr_idx;
    logic [RIW-1:0] reg_idx;
    logic [43:0]    reg_num;
    logic           req_ok, region_ok;

    // An address below BASE_ADDR wraps to a huge offset and falls through to unmapped.
    assign offset   = mem_addr_i - BASE_ADDR;
    assign reg_num  = offset[63:20];
    assign csr_hit  = (offset[63:16] < 48'(CSR_WORDS)) && ((offset[15:0] >> WB) == 16'd0);
    assign stat_hit = (offset[63:16] == 48'(CSR_WORDS)) && ((offset[15:0] >> WB) == 16'd0);
    assign reg_hit  = (reg_num >= 44'd1) && (reg_num <= 44'(NUM_REGIONS))
                      && (64'(offset[19:0]) < REGION_BYTES);
    assign csr_idx  = CIW'(offset[63:16]);
    assign reg_idx  = RIW'(reg_num - 44'd1);

    // A request that arrives while reset is asserted is dropped entirely.
    assign req_ok    = mem_req_i && !rst_i;
    assign region_ok = req_ok && reg_hit && !busy_i;

    // ---------------- SRAM side (combinational in request cycle) ----------------
    assign sram_req_o   = region_ok ? (NUM_REGIONS'(1) << reg_idx) : '0;
    assign sram_we_o    = mem_write_en_i;
    assign sram_be_o    = mem_byte_en_i;
    assign sram_addr_o  = AW'(offset[19:0] >> WB);
    assign sram_wdata_o = mem_wdata_i;

    // ---------------- state ----------------
    logic [DATA_W-1:0] csr_q [CSR_WORDS];
    logic [DATA_W-1:0] csr_d [CSR_WORDS];
    logic              rvalid_q, err_q, err_d, start_q, start_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_region_q;
    logic [RIW-1:0]    ridx_q;
    logic [DATA_W-1:0] merged;

    always_comb begin
        csr_d   = csr_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        merged  = '0;
        // The start field is visible for the single cycle start_o is high,
        // then clears itself.
        if (start_q) begin
            csr_d[0][START_HI:START_LO] = 2'b00;
        end
        if (req_ok) begin
            if (csr_hit) begin
                if (mem_write_en_i) begin
                    merged = csr_d[csr_idx];
                    for (int b = 0; b < BYTES; b++) begin
                        if (mem_byte_en_i[b]) begin
                            merged[b*8 +: 8] = mem_wdata_i[b*8 +: 8];
                        end
                    end
                    if ((csr_idx == CIW'(0)) && (merged[START_HI:START_LO] != 2'b00)) begin
                        if (busy_i) begin
                            // The start is refused, but the other bytes still land.
                            merged[START_HI:START_LO] = 2'b00;
                            err_d = 1'b1;
                        end else begin
                            start_d = 1'b1;
                        end
                    end
                    csr_d[csr_idx] = merged;
                end else begin
                    rdata_d = csr_q[csr_idx];
                end
            end else if (stat_hit) begin
                if (mem_write_en_i) begin
                    err_d = 1'b1;
                end else begin
                    rdata_d = DATA_W'({busy_i, op_done_i});
                end
            end else if (reg_hit) begin
                err_d = busy_i;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < CSR_WORDS; k++) begin
                csr_q[k] <= '0;
            end
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            start_q     <= 1'b0;
            rd_region_q <= 1'b0;
            ridx_q      <= '0;
        end else begin
            csr_q       <= csr_d;
            rvalid_q    <= mem_req_i;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            start_q     <= start_d;
            rd_region_q <= region_ok && !mem_write_en_i;
            ridx_q      <= reg_idx;
        end
    end

    // ---------------- outputs ----------------
    assign mem_rvalid_o = rvalid_q;
    assign mem_err_o    = err_q;
    assign start_o      = start_q;
    // Region read data comes straight from the SRAM, which has 1-cycle latency.
    // All other responses come from rdata_q, which is 0 when nothing was read.
    assign mem_rdata_o  = rd_region_q ? sram_rdata_i[ridx_q*DATA_W +: DATA_W] : rdata_q;

    for (genvar k = 0; k < CSR_WORDS; k++) begin : g_csr_out
        assign csr_o[k*DATA_W +: DATA_W] = csr_q[k];
    end

endmodule

// File: tb/tb_octree_mem_bridge.sv
// Self-checking bench for octree_mem_bridge with the default parameters.
// Stimulus issues requests and pushes {err, rdata} onto exp_q. A monitor pops
// and compares one entry on every mem_rvalid_o. A behavioural SRAM provides
// storage for the two regions.
module tb_octree_mem_bridge;

  localparam int W = 65;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          mem_req_i, mem_write_en_i;
  logic [7:0]    mem_byte_en_i;
  logic [63:0]   mem_addr_i, mem_wdata_i;
  logic [63:0]   mem_rdata_o;
  logic          mem_rvalid_o, mem_err_o;
  logic [127:0]  csr_o;
  logic          start_o;
  logic          busy_i;
  logic [1:0]    op_done_i;
  logic [1:0]    sram_req_o;
  logic          sram_we_o;
  logic [7:0]    sram_be_o;
  logic [9:0]    sram_addr_o;
  logic [63:0]   sram_wdata_o;
  logic [127:0]  sram_rdata_i;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock/reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  octree_mem_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_i(mem_req_i), .mem_write_en_i(mem_write_en_i),
    .mem_byte_en_i(mem_byte_en_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o),
    .csr_o(csr_o), .start_o(start_o), .busy_i(busy_i), .op_done_i(op_done_i),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i)
  );

  // ---------------- behavioural SRAM, 1-cycle read latency ----------------
  logic [63:0] sram_mem [2][1024];
  logic [63:0] sram_rd [2];

  assign sram_rdata_i = {sram_rd[1], sram_rd[0]};

  always @(posedge clk_i) begin
    for (int r = 0; r < 2; r++) begin
      if (sram_req_o[r]) begin
        if (sram_we_o) begin
          for (int b = 0; b < 8; b++) begin
            if (sram_be_o[b]) sram_mem[r][sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
          end
        end else begin
          sram_rd[r] <= sram_mem[r][sram_addr_o];
        end
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (mem_rvalid_o === 1'b1) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got rdata=%h err=%b expected no response", mem_rdata_o, mem_err_o);
      end else begin
        e = exp_q.pop_front();
        if (mem_rdata_o !== e[63:0] || mem_err_o !== e[64]) begin
          errors++;
          $display("FAIL response: got rdata=%h err=%b expected rdata=%h err=%b",
                   mem_rdata_o, mem_err_o, e[63:0], e[64]);
        end
      end
    end else if (mem_rvalid_o !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL rvalid_x: got %b expected 0 or 1", mem_rvalid_o);
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one request in the current cycle and pushes its expected response.
  task automatic drive(input logic we, input logic [7:0] be, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee);
    mem_req_i      = 1'b1;
    mem_write_en_i = we;
    mem_byte_en_i  = be;
    mem_addr_i     = addr;
    mem_wdata_i    = wd;
    exp_q.push_back({ee, er});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    mem_req_i      = 1'b0;
    mem_write_en_i = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [7:0] be, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee);
    drive(we, be, addr, wd, er, ee);
    step();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'(i) ^ 32'hA5A5_0000, ~32'(i)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; mem_req_i = 1'b0; mem_write_en_i = 1'b0; mem_byte_en_i = '0;
    mem_addr_i = '0; mem_wdata_i = '0; busy_i = 1'b0; op_done_i = 2'b00;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("reset_csr", csr_o[63:0] | csr_o[127:64], 64'd0);
    check("reset_rvalid", 64'(mem_rvalid_o), 64'd0);
    check("reset_start", 64'(start_o), 64'd0);
    check("reset_rdata", mem_rdata_o, 64'd0);

    // Region 1 word 2 write / read back
    drive(1'b1, 8'hFF, 64'h6020_0010, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0);
    #1;
    check("r1_sram_req", 64'(sram_req_o), 64'h2);
    check("r1_sram_addr", 64'(sram_addr_o), 64'd2);
    step();
    issue(1'b0, 8'hFF, 64'h6020_0010, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    // Address bits below the word size are ignored.
    issue(1'b0, 8'hFF, 64'h6020_0013, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    drain();

    // CSR0 partial byte write
    issue(1'b1, 8'h0F, 64'h6000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    check("csr0_partial", csr_o[63:0], 64'h0000_0000_FFFF_FFFF);
    issue(1'b0, 8'hFF, 64'h6000_0000, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b0);
    drain();

    // Start pulse: start_o rises in the ack cycle and lasts one cycle.
    issue(1'b1, 8'h40, 64'h6000_0000, 64'h0001_0000_0000_0000, 64'd0, 1'b0);
    check("start_pulse_hi", 64'(start_o), 64'd1);
    @(posedge clk_i);
    #1;
    check("start_pulse_lo", 64'(start_o), 64'd0);
    check("start_selfclear", 64'(csr_o[49:48]), 64'd0);
    issue(1'b0, 8'hFF, 64'h6000_0000, 64'd0, 64'h0000_0000_FFFF_FFFF, 1'b0);
    drain();

    // Busy: region writes rejected, start refused, other bytes written
    busy_i = 1'b1;
    drive(1'b1, 8'hFF, 64'h6010_0000, 64'hDEAD_BEEF_0000_0001, 64'd0, 1'b1);
    #1;
    check("busy_no_sram_req", 64'(sram_req_o), 64'd0);
    step();
    issue(1'b0, 8'hFF, 64'h6020_0010, 64'd0, 64'd0, 1'b1);
    issue(1'b1, 8'hC0, 64'h6000_0000, 64'hAB03_0000_0000_0000, 64'd0, 1'b1);
    check("busy_start_refused", 64'(start_o), 64'd0);
    check("busy_csr0_bytes", csr_o[63:0], 64'hAB00_0000_FFFF_FFFF);
    // Status read with busy, then unmapped
    op_done_i = 2'b10;
    issue(1'b0, 8'hFF, 64'h6080_0000, 64'd0, 64'd0, 1'b1);
    issue(1'b0, 8'hFF, 64'h6002_0000, 64'd0, 64'h6, 1'b0);
    issue(1'b1, 8'hFF, 64'h6002_0000, 64'hFFFF, 64'd0, 1'b1);
    busy_i = 1'b0;
    op_done_i = 2'b01;
    drive(1'b1, 8'hFF, 64'h6010_0000, 64'hDEAD_BEEF_0000_0001, 64'd0, 1'b0);
    #1;
    check("idle_sram_req", 64'(sram_req_o), 64'h1);
    step();
    issue(1'b0, 8'hFF, 64'h6010_0000, 64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    issue(1'b0, 8'hFF, 64'h6002_0000, 64'd0, 64'h1, 1'b0);
    // CSR1 full write and read back; region past DEPTH and below base are unmapped
    issue(1'b1, 8'hFF, 64'h6001_0000, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 1'b0);
    issue(1'b0, 8'hFF, 64'h6001_0000, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
    issue(1'b0, 8'hFF, 64'h6010_2000, 64'd0, 64'd0, 1'b1);
    issue(1'b0, 8'hFF, 64'h5FFF_FFF8, 64'd0, 64'd0, 1'b1);
    issue(1'b1, 8'hFF, 64'h6030_0000, 64'h55, 64'd0, 1'b1);
    drain();
    check("csr1_value", csr_o[127:64], 64'h0F0E_0D0C_0B0A_0908);

    // Back-to-back burst over region 0
    for (int i = 0; i < 1024; i++)
      issue(1'b1, 8'hFF, 64'h6010_0000 + 64'(i) * 64'd8, pat(i), 64'd0, 1'b0);
    for (int i = 0; i < 1024; i++)
      issue(1'b0, 8'hFF, 64'h6010_0000 + 64'(i) * 64'd8, 64'd0, pat(i), 1'b0);
    drain();

    // Reset mid-burst: the request that coincides with reset, a start write, is dropped.
    for (int i = 0; i < 3; i++)
      issue(1'b0, 8'hFF, 64'h6010_0000 + 64'(i) * 64'd8, 64'd0, pat(i), 1'b0);
    rst_i = 1'b1;
    mem_req_i = 1'b1; mem_write_en_i = 1'b1; mem_byte_en_i = 8'hFF;
    mem_addr_i = 64'h6000_0000; mem_wdata_i = 64'h0003_0000_0000_0000;
    #1;
    check("reset_sram_req", 64'(sram_req_o), 64'd0);
    step();
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("post_reset_rvalid", 64'(mem_rvalid_o), 64'd0);
      check("post_reset_start", 64'(start_o), 64'd0);
      @(posedge clk_i);
      #1;
    end
    check("post_reset_csr0", csr_o[63:0], 64'd0);
    check("post_reset_csr1", csr_o[127:64], 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
